// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game-step sequencer: FSM states, directions,
// {x, y} position packing and the pixel bitmap index.
package snake_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StFood,
    StWait,
    StMove,
    StCheck,
    StCommit,
    StDead
  } state_e;

  // Up decrements y (row 0 is the top row of the matrix).
  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } pos_t;

  function automatic logic [7:0] pack_pos(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

  function automatic pos_t unpack_pos(input logic [7:0] p);
    return pos_t'(p);
  endfunction

  function automatic logic [6:0] pixel_index(input logic [3:0] x, input logic [3:0] y);
    return 7'((int'(y) * 16) + int'(x));
  endfunction

  // Encodings pair up so that flipping bit 0 yields the opposite direction.
  function automatic dir_e dir_reverse(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_wrap_step.sv
// One-cell step of the snake head in the given direction, wrapping at the matrix edges.
module snake_wrap_step
  import snake_pkg::*;
#(
  parameter int unsigned COLS = 16,
  parameter int unsigned ROWS = 8
) (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  dir_e       dir,
  output logic [3:0] next_x,
  output logic [3:0] next_y
);

  localparam logic [3:0] XMax = 4'(COLS - 1);
  localparam logic [3:0] YMax = 4'(ROWS - 1);

  always_comb begin
    next_x = x;
    next_y = y;
    unique case (dir)
      DirUp:    next_y = (y == 4'd0) ? YMax : y - 4'd1;
      DirDown:  next_y = (y == YMax) ? 4'd0 : y + 4'd1;
      DirLeft:  next_x = (x == 4'd0) ? XMax : x - 4'd1;
      DirRight: next_x = (x == XMax) ? 4'd0 : x + 4'd1;
    endcase
  end

endmodule

// File: rtl/snake_sequencer.sv
// Snake game-step sequencer: owns head, occupancy bitmap and score, and runs the
// move/check/commit sequence against an external show-ahead body FIFO and food randomizer.
module snake_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned COLS      = 16,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned START_LEN = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic         btnUp,
  input  logic         btnDown,
  input  logic         btnLeft,
  input  logic         btnRight,
  output logic         fifo_clr,
  output logic         fifo_push,
  output logic [7:0]   fifo_din,
  output logic         fifo_pop,
  input  logic [7:0]   fifo_tail,
  output logic         food_req,
  input  logic         food_vld,
  input  logic [7:0]   food_pos,
  output logic [127:0] pixelReg,
  output logic [7:0]   score,
  output logic         alive,
  output logic         win
);

  localparam int unsigned    LenW     = $clog2(MAX_LEN + 1);
  localparam logic [LenW-1:0] LastLen = LenW'(MAX_LEN - 1);
  localparam logic [3:0]     StartY   = 4'(ROWS / 2);
  localparam logic [3:0]     InitLast = 4'(START_LEN - 1);

  state_e          state;
  dir_e            dir, dir_req, btn_dir;
  logic            btn_any, start_q, start_rise, pending, grow_q;
  logic [3:0]      head_x, head_y, init_cnt, step_x, step_y;
  logic [7:0]      food_q, tail_q;
  logic [LenW-1:0] len;
  pos_t            next_pos, tail_pos, food_in;
  logic            grow, hit;

  snake_wrap_step #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_wrap_step (
    .x     (head_x),
    .y     (head_y),
    .dir   (dir_req),
    .next_x(step_x),
    .next_y(step_y)
  );

  always_comb begin
    btn_any = btnUp | btnDown | btnLeft | btnRight;
    if (btnUp)        btn_dir = DirUp;
    else if (btnDown) btn_dir = DirDown;
    else if (btnLeft) btn_dir = DirLeft;
    else              btn_dir = DirRight;
  end

  assign start_rise = start & ~start_q;
  assign next_pos   = unpack_pos(fifo_din);
  assign tail_pos   = unpack_pos(tail_q);
  assign food_in    = unpack_pos(food_pos);
  // The food bit lives in the bitmap but is not body; a cell the tail vacates is free.
  assign grow = (fifo_din == food_q);
  assign hit  = pixelReg[pixel_index(next_pos.x, next_pos.y)] & ~grow & (fifo_din != fifo_tail);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      dir       <= DirRight;
      dir_req   <= DirRight;
      start_q   <= 1'b0;
      pending   <= 1'b0;
      grow_q    <= 1'b0;
      head_x    <= 4'd0;
      head_y    <= 4'd0;
      init_cnt  <= 4'd0;
      food_q    <= 8'd0;
      tail_q    <= 8'd0;
      len       <= '0;
      fifo_clr  <= 1'b0;
      fifo_push <= 1'b0;
      fifo_din  <= 8'd0;
      fifo_pop  <= 1'b0;
      food_req  <= 1'b0;
      pixelReg  <= '0;
      score     <= 8'd0;
      alive     <= 1'b0;
      win       <= 1'b0;
    end else begin
      start_q   <= start;
      fifo_clr  <= 1'b0;
      fifo_push <= 1'b0;
      fifo_pop  <= 1'b0;
      food_req  <= 1'b0;
      if (state != StIdle && state != StDead && btn_any && btn_dir != dir_reverse(dir)) begin
        dir_req <= btn_dir;
      end
      if (tick && (state inside {StFood, StMove, StCheck, StCommit})) begin
        pending <= 1'b1;
      end

      unique case (state)
        StIdle, StDead: begin
          if (start_rise) begin
            state    <= StInit;
            fifo_clr <= 1'b1;
            pixelReg <= '0;
            score    <= 8'd0;
            win      <= 1'b0;
            len      <= '0;
            alive    <= 1'b1;
            init_cnt <= 4'd0;
            dir      <= DirRight;
            dir_req  <= DirRight;
            pending  <= 1'b0;
          end
        end
        StInit: begin
          fifo_push <= 1'b1;
          fifo_din  <= pack_pos(init_cnt, StartY);
          pixelReg[pixel_index(init_cnt, StartY)] <= 1'b1;
          head_x    <= init_cnt;
          head_y    <= StartY;
          len       <= len + 1'b1;
          init_cnt  <= init_cnt + 4'd1;
          if (init_cnt == InitLast) begin
            state    <= StFood;
            food_req <= 1'b1;
          end
        end
        StFood: begin
          // Valid data never coincides with the request cycle itself.
          if (!food_req && food_vld) begin
            if (pixelReg[pixel_index(food_in.x, food_in.y)]) begin
              food_req <= 1'b1;
            end else begin
              food_q <= food_pos;
              pixelReg[pixel_index(food_in.x, food_in.y)] <= 1'b1;
              state  <= StWait;
            end
          end
        end
        StWait: begin
          if (tick || pending) begin
            state   <= StMove;
            pending <= 1'b0;
          end
        end
        StMove: begin
          fifo_din <= pack_pos(step_x, step_y);
          dir      <= dir_req;
          state    <= StCheck;
        end
        StCheck: begin
          if (hit) begin
            state <= StDead;
            alive <= 1'b0;
          end else begin
            state     <= StCommit;
            fifo_push <= 1'b1;
            fifo_pop  <= ~grow;
            grow_q    <= grow;
            tail_q    <= fifo_tail;
          end
        end
        StCommit: begin
          pixelReg[pixel_index(next_pos.x, next_pos.y)] <= 1'b1;
          head_x <= next_pos.x;
          head_y <= next_pos.y;
          if (grow_q) begin
            len <= len + 1'b1;
            if (score != 8'hFF) score <= score + 8'd1;
            if (len == LastLen) begin
              state <= StDead;
              alive <= 1'b0;
              win   <= 1'b1;
            end else begin
              state    <= StFood;
              food_req <= 1'b1;
            end
          end else begin
            if (tail_q != fifo_din) pixelReg[pixel_index(tail_pos.x, tail_pos.y)] <= 1'b0;
            state <= StWait;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_sequencer.sv
// Bench for snake_sequencer: show-ahead FIFO model, scripted food randomizer and a push
// scoreboard checked scenario by scenario.
module tb_snake_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1, tick = 1'b0, start = 1'b0;
  logic         btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
  logic         fifo_clr, fifo_push, fifo_pop, food_req, alive, win;
  logic [7:0]   fifo_din, score;
  logic [7:0]   fifo_tail = 8'h00;
  logic         food_vld = 1'b0;
  logic [7:0]   food_pos = 8'h00;
  logic [127:0] pixelReg;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] act_mem[256];
  int         act_wr = 0;
  int         rd_idx = 0;
  logic [7:0] food_mem[64];
  int         food_wr = 0;
  int         food_rd = 0;
  int         pop_cnt = 0, clr_cnt = 0, req_cnt = 0;
  logic [7:0] fifo_q[$];

  always #5 clk = ~clk;

  snake_sequencer #(
    .COLS(16), .ROWS(8), .MAX_LEN(64), .START_LEN(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .fifo_clr(fifo_clr), .fifo_push(fifo_push), .fifo_din(fifo_din), .fifo_pop(fifo_pop),
    .fifo_tail(fifo_tail), .food_req(food_req), .food_vld(food_vld), .food_pos(food_pos),
    .pixelReg(pixelReg), .score(score), .alive(alive), .win(win)
  );

  // Show-ahead body FIFO
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_q.delete();
    end else begin
      if (fifo_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (fifo_push) fifo_q.push_back(fifo_din);
    end
    fifo_tail <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // Randomizer: answers each request on the following cycle from the scripted list
  always @(posedge clk) begin
    food_vld <= 1'b0;
    if (food_req) begin
      food_vld <= 1'b1;
      if (food_rd < food_wr) begin
        food_pos <= food_mem[food_rd];
        food_rd  <= food_rd + 1;
      end else begin
        food_pos <= 8'h77;
      end
    end
  end

  always @(negedge clk) begin
    if (fifo_push && act_wr < 256) begin
      act_mem[act_wr] = fifo_din;
      act_wr++;
    end
    if (fifo_pop) pop_cnt++;
    if (fifo_clr) clr_cnt++;
    if (food_req) req_cnt++;
  end

  function automatic int pidx(int x, int y);
    return y * 16 + x;
  endfunction

  task automatic add_food(input logic [7:0] p);
    food_mem[food_wr] = p;
    food_wr++;
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic step(input logic [7:0] exp_push);
    if (exp_push != 8'hFF) exp_q.push_back(exp_push);
    pulse_tick();
    repeat (12) @(negedge clk);
  endtask

  task automatic start_game();
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h14);
    exp_q.push_back(8'h24);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({fifo_clr, fifo_push, fifo_pop, food_req, alive, win} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %06b, required 000000",
               {fifo_clr, fifo_push, fifo_pop, food_req, alive, win});
    end
    tests++;
    if (fifo_din !== 8'h00 || score !== 8'h00) begin
      fails++;
      $display("FAIL reset_din_score: got din=%02h score=%0d, required 00 and 0", fifo_din, score);
    end
    tests++;
    if (pixelReg !== 128'd0) begin
      fails++;
      $display("FAIL reset_pixels: got %032h, required 0", pixelReg);
    end
    reset = 1'b0;
    @(negedge clk);
    rd_idx = act_wr;
  endtask

  task automatic test_start();
    int clr0, req0;
    logic [127:0] exp_pix;
    logic [7:0] e;
    clr0 = clr_cnt;
    req0 = req_cnt;
    add_food(8'h14);  // on the body: must be re-requested
    add_food(8'h44);
    start_game();
    tests++;
    if (clr_cnt - clr0 != 1) begin
      fails++;
      $display("FAIL start_clr: got %0d pulses, required 1", clr_cnt - clr0);
    end
    tests++;
    if (req_cnt - req0 != 2) begin
      fails++;
      $display("FAIL start_food_req: got %0d pulses, required 2", req_cnt - req0);
    end
    tests++;
    if (alive !== 1'b1) begin
      fails++;
      $display("FAIL start_alive: got %b, required 1", alive);
    end
    exp_pix = '0;
    exp_pix[pidx(0, 4)] = 1'b1;
    exp_pix[pidx(1, 4)] = 1'b1;
    exp_pix[pidx(2, 4)] = 1'b1;
    exp_pix[pidx(4, 4)] = 1'b1;
    tests++;
    if (pixelReg !== exp_pix) begin
      fails++;
      $display("FAIL start_pixels: got %032h, required %032h", pixelReg, exp_pix);
    end
    tests++;
    if (act_wr - rd_idx != exp_q.size()) begin
      fails++;
      $display("FAIL start_push_count: got %0d, required %0d", act_wr - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < act_wr) begin
      e = exp_q.pop_front();
      tests++;
      if (act_mem[rd_idx] !== e) begin
        fails++;
        $display("FAIL start_push: got %02h, required %02h", act_mem[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_wr;
  endtask

  task automatic test_grow();
    int pop0, req0;
    logic [127:0] exp_pix;
    logic [7:0] e;
    pop0 = pop_cnt;
    step(8'h34);
    exp_pix = '0;
    exp_pix[pidx(1, 4)] = 1'b1;
    exp_pix[pidx(2, 4)] = 1'b1;
    exp_pix[pidx(3, 4)] = 1'b1;
    exp_pix[pidx(4, 4)] = 1'b1;
    tests++;
    if (pixelReg !== exp_pix || pop_cnt - pop0 != 1) begin
      fails++;
      $display("FAIL move_tail: got pix=%032h pops=%0d, required %032h and 1",
               pixelReg, pop_cnt - pop0, exp_pix);
    end
    pop0 = pop_cnt;
    req0 = req_cnt;
    add_food(8'h03);
    step(8'h44);
    exp_pix[pidx(0, 3)] = 1'b1;
    tests++;
    if (pop_cnt - pop0 != 0) begin
      fails++;
      $display("FAIL grow_no_pop: got %0d pops, required 0", pop_cnt - pop0);
    end
    tests++;
    if (score !== 8'd1 || req_cnt - req0 != 1) begin
      fails++;
      $display("FAIL grow_score: got score=%0d reqs=%0d, required 1 and 1", score, req_cnt - req0);
    end
    tests++;
    if (pixelReg !== exp_pix) begin
      fails++;
      $display("FAIL grow_pixels: got %032h, required %032h", pixelReg, exp_pix);
    end
    tests++;
    if (act_wr - rd_idx != exp_q.size()) begin
      fails++;
      $display("FAIL grow_push_count: got %0d, required %0d", act_wr - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < act_wr) begin
      e = exp_q.pop_front();
      tests++;
      if (act_mem[rd_idx] !== e) begin
        fails++;
        $display("FAIL grow_push: got %02h, required %02h", act_mem[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_wr;
  endtask

  task automatic test_wrap();
    int lat;
    logic [7:0] e;
    for (int x = 5; x < 16; x++) step({4'(x), 4'd4});
    exp_q.push_back(8'h04);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    lat = 1;
    while (fifo_push !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL wrap_latency: got %0d cycles, required 3", lat);
    end
    tests++;
    if (fifo_pop !== 1'b1 || pixelReg[64] !== 1'b0) begin
      fails++;
      $display("FAIL wrap_commit: got pop=%b bit64=%b, required 1 and 0", fifo_pop, pixelReg[64]);
    end
    @(negedge clk);
    tests++;
    if (pixelReg[64] !== 1'b1 || pixelReg[pidx(12, 4)] !== 1'b0) begin
      fails++;
      $display("FAIL wrap_pixels: got bit64=%b bit76=%b, required 1 and 0",
               pixelReg[64], pixelReg[pidx(12, 4)]);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (act_wr - rd_idx != exp_q.size()) begin
      fails++;
      $display("FAIL wrap_push_count: got %0d, required %0d", act_wr - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < act_wr) begin
      e = exp_q.pop_front();
      tests++;
      if (act_mem[rd_idx] !== e) begin
        fails++;
        $display("FAIL wrap_push: got %02h, required %02h", act_mem[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_wr;
  endtask

  task automatic test_body_hit();
    logic [7:0] e;
    add_food(8'h80);
    @(negedge clk) btnUp = 1'b1;
    @(negedge clk) btnUp = 1'b0;
    step(8'h03);
    tests++;
    if (score !== 8'd2) begin
      fails++;
      $display("FAIL hit_score: got %0d, required 2", score);
    end
    @(negedge clk) btnLeft = 1'b1;
    @(negedge clk) btnLeft = 1'b0;
    step(8'hF3);
    @(negedge clk) btnDown = 1'b1;
    @(negedge clk) btnDown = 1'b0;
    step(8'hFF);
    tests++;
    if (alive !== 1'b0 || win !== 1'b0) begin
      fails++;
      $display("FAIL hit_dead: got alive=%b win=%b, required 0 and 0", alive, win);
    end
    tests++;
    if (act_wr - rd_idx != exp_q.size()) begin
      fails++;
      $display("FAIL hit_push_count: got %0d, required %0d", act_wr - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < act_wr) begin
      e = exp_q.pop_front();
      tests++;
      if (act_mem[rd_idx] !== e) begin
        fails++;
        $display("FAIL hit_push: got %02h, required %02h", act_mem[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_wr;
  endtask

  task automatic test_reverse();
    int pop0;
    logic [7:0] e;
    add_food(8'h34);
    add_food(8'h77);
    start_game();
    pop0 = pop_cnt;
    @(negedge clk) btnLeft = 1'b1;
    @(negedge clk) btnLeft = 1'b0;
    step(8'h34);
    tests++;
    if (score !== 8'd1 || alive !== 1'b1 || pop_cnt - pop0 != 0) begin
      fails++;
      $display("FAIL reverse_step: got score=%0d alive=%b pops=%0d, required 1, 1 and 0",
               score, alive, pop_cnt - pop0);
    end
    tests++;
    if (act_wr - rd_idx != exp_q.size()) begin
      fails++;
      $display("FAIL reverse_push_count: got %0d, required %0d", act_wr - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < act_wr) begin
      e = exp_q.pop_front();
      tests++;
      if (act_mem[rd_idx] !== e) begin
        fails++;
        $display("FAIL reverse_push: got %02h, required %02h", act_mem[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_wr;
  endtask

  task automatic test_tail_follow();
    logic [127:0] exp_pix;
    logic [7:0] e;
    @(negedge clk) btnUp = 1'b1;
    @(negedge clk) btnUp = 1'b0;
    step(8'h33);
    @(negedge clk) btnLeft = 1'b1;
    @(negedge clk) btnLeft = 1'b0;
    step(8'h23);
    @(negedge clk) btnDown = 1'b1;
    @(negedge clk) btnDown = 1'b0;
    step(8'h24);  // lands on the cell the tail is vacating
    tests++;
    if (alive !== 1'b1) begin
      fails++;
      $display("FAIL tail_alive: got %b, required 1", alive);
    end
    exp_pix = '0;
    exp_pix[pidx(3, 4)] = 1'b1;
    exp_pix[pidx(3, 3)] = 1'b1;
    exp_pix[pidx(2, 3)] = 1'b1;
    exp_pix[pidx(2, 4)] = 1'b1;
    exp_pix[pidx(7, 7)] = 1'b1;
    tests++;
    if (pixelReg !== exp_pix) begin
      fails++;
      $display("FAIL tail_pixels: got %032h, required %032h", pixelReg, exp_pix);
    end
    tests++;
    if (act_wr - rd_idx != exp_q.size()) begin
      fails++;
      $display("FAIL tail_push_count: got %0d, required %0d", act_wr - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < act_wr) begin
      e = exp_q.pop_front();
      tests++;
      if (act_mem[rd_idx] !== e) begin
        fails++;
        $display("FAIL tail_push: got %02h, required %02h", act_mem[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_wr;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    exp_q.push_back(8'h25);
    exp_q.push_back(8'h26);
    // Tick in WAIT, then again in MOVE and CHECK: only one extra step may result.
    @(negedge clk) tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    repeat (30) @(negedge clk);
    tests++;
    if (act_wr - rd_idx != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_push_count: got %0d, required %0d", act_wr - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < act_wr) begin
      e = exp_q.pop_front();
      tests++;
      if (act_mem[rd_idx] !== e) begin
        fails++;
        $display("FAIL b2b_push: got %02h, required %02h", act_mem[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_wr;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [7:0] e;
    exp_q.push_back(8'h27);
    pulse_tick();
    n = 0;
    while (fifo_push !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (fifo_push !== 1'b1) begin
      fails++;
      $display("FAIL midreset_commit: got push=%b after %0d cycles, required 1", fifo_push, n);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({fifo_clr, fifo_push, fifo_pop, food_req, alive, win} !== 6'b0 || fifo_din !== 8'h00 ||
        score !== 8'h00 || pixelReg !== 128'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got flags=%06b din=%02h score=%0d pix=%032h, required 0",
               {fifo_clr, fifo_push, fifo_pop, food_req, alive, win}, fifo_din, score, pixelReg);
    end
    reset = 1'b0;
    step(8'hFF);  // idle: a tick must not move anything
    tests++;
    if (act_wr - rd_idx != exp_q.size()) begin
      fails++;
      $display("FAIL midreset_push_count: got %0d, required %0d", act_wr - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < act_wr) begin
      e = exp_q.pop_front();
      tests++;
      if (act_mem[rd_idx] !== e) begin
        fails++;
        $display("FAIL midreset_push: got %02h, required %02h", act_mem[rd_idx], e);
      end
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_wr;
  endtask

  initial begin
    test_reset();
    test_start();
    test_grow();
    test_wrap();
    test_body_hit();
    test_reverse();
    test_tail_follow();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
